// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, 16x oversampled, 2-of-3 majority vote on ticks 7/8/9.
// Decisions run on the synchronized line rxs; outputs are all registered.
module uart_rx_oversampled #(
  parameter int CLKS_PER_TICK = 27,
  parameter int MIN_TICKS     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rxReady,
  output logic [7:0] rxData,
  output logic       rxFrameErr,
  output logic       rxBusy
);

  localparam int DIV_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(CLKS_PER_TICK - 1);

  // A divider shorter than MIN_TICKS cannot separate the vote pipeline from
  // the bit-boundary decisions, so refuse to elaborate.
  if (CLKS_PER_TICK < MIN_TICKS) begin : g_bad_cfg
    $error("uart_rx_oversampled: CLKS_PER_TICK below MIN_TICKS");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic             rx_meta_q, rxs_q, rxs_prev_q;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             s7_q, s7_d, s8_q, s8_d;
  logic             maj_q, maj_d, maj_vld_q, maj_vld_d;
  logic [7:0]       shift_q, shift_d, data_q, data_d;
  logic             ready_q, ready_d, ferr_q, ferr_d, busy_q;
  logic             brk_hi_q, brk_hi_d;
  logic             tick, fall, vote;

  assign tick = (div_q == TICK_LAST);
  assign fall = rxs_prev_q & ~rxs_q;
  assign vote = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Next-state logic: tick sampling, majority pipeline and frame sequencing.
  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    s7_d      = s7_q;
    s8_d      = s8_q;
    maj_d     = maj_q;
    maj_vld_d = 1'b0;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
    brk_hi_d  = brk_hi_q;

    // Sample points within a bit; the vote is registered and acted on one
    // cycle later so each state sees a clean maj_vld_q strobe.
    if ((state_q == START || state_q == DATA || state_q == STOP) && tick) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd7) s7_d = rxs_q;
      if (cnt_q == 4'd8) s8_d = rxs_q;
      if (cnt_q == 4'd9) begin
        maj_d     = vote;
        maj_vld_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          div_d   = '0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (maj_vld_q && maj_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick && cnt_q == 4'd15) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (maj_vld_q) shift_d = {maj_q, shift_q[7:1]};
        if (tick && cnt_q == 4'd15) begin
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        // Leave right after the vote so a back-to-back start edge is seen.
        if (maj_vld_q) begin
          cnt_d = '0;
          if (maj_q) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d   = 1'b1;
            brk_hi_d = 1'b0;
            state_d  = BREAK;
          end
        end
      end
      BREAK: begin
        // Exit only after the line stayed high across one whole tick period.
        if (tick) begin
          if (brk_hi_q && rxs_q) state_d = IDLE;
          brk_hi_d = rxs_q;
        end else if (!rxs_q) begin
          brk_hi_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      s7_q      <= 1'b1;
      s8_q      <= 1'b1;
      maj_q     <= 1'b1;
      maj_vld_q <= 1'b0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
      brk_hi_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      s7_q      <= s7_d;
      s8_q      <= s8_d;
      maj_q     <= maj_d;
      maj_vld_q <= maj_vld_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      busy_q    <= (state_d != IDLE);
      brk_hi_q  <= brk_hi_d;
    end
  end

  assign rxReady    = ready_q;
  assign rxData     = data_q;
  assign rxFrameErr = ferr_q;
  assign rxBusy     = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled at CLKS_PER_TICK=4 (64 clk per bit).
// Expected bytes go into a queue as frames are sent; a monitor pops them.
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rxReady;
  logic [7:0] rxData;
  logic       rxFrameErr;
  logic       rxBusy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int ready_cnt = 0;
  int ferr_cnt  = 0;
  int last_ready_cyc = -1;
  logic [7:0] exp_q[$];

  uart_rx_oversampled #(.CLKS_PER_TICK(4), .MIN_TICKS(2)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .rxReady(rxReady), .rxData(rxData),
    .rxFrameErr(rxFrameErr), .rxBusy(rxBusy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: scoreboard pops on rxReady, pulse exclusivity check.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rxReady || rxFrameErr) begin
        n_checks++;
        if (rxReady && rxFrameErr) begin
          n_fail++;
          $display("FAIL pulse_excl: rxReady=%0b rxFrameErr=%0b, required not both", rxReady, rxFrameErr);
        end
      end
      if (rxReady) begin
        ready_cnt++;
        last_ready_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: unexpected byte %02h at cycle %0d, required none", rxData, cyc);
        end else begin
          e = exp_q.pop_front();
          if (rxData !== e) begin
            n_fail++;
            $display("FAIL scoreboard: rxData=%02h, required %02h", rxData, e);
          end else begin
            $display("rx byte %02h at cycle %0d", rxData, cyc);
          end
        end
      end
      if (rxFrameErr) begin
        ferr_cnt++;
        $display("rx frame error at cycle %0d", cyc);
      end
    end
  end

  // Drive one 8N1 frame; optional low spike in one frame position (clk 35..38
  // of that bit), optional 1-clk reset pulse after which the line idles high.
  task automatic send_frame(input logic [7:0] d, input int period, input logic stop_v,
                            input int spike_pos, input int rst_pos);
    logic [9:0] fr;
    logic aborted;
    fr = {stop_v, d, 1'b0};
    aborted = 1'b0;
    start_cyc = cyc;
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < period; c++) begin
        reset = (p == rst_pos && c == 30);
        if (reset) aborted = 1'b1;
        if (aborted) rx = 1'b1;
        else if (p == spike_pos && c >= 35 && c < 39) rx = 1'b0;
        else rx = fr[p];
        @(posedge clk);
        #1;
      end
    end
    reset = 1'b0;
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    idle(3);
    n_checks += 4;
    if (rxData !== 8'h00) begin n_fail++; $display("FAIL reset_data: rxData=%02h, required 00", rxData); end
    if (rxReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready: rxReady=%0b, required 0", rxReady); end
    if (rxFrameErr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: rxFrameErr=%0b, required 0", rxFrameErr); end
    if (rxBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: rxBusy=%0b, required 0", rxBusy); end
    reset = 1'b0;
    idle(20);
    $display("reset checked");
  endtask

  task automatic test_single;
    int r0, f0;
    r0 = ready_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 64, 1'b1, -1, -1);
    idle(40);
    n_checks += 4;
    if (ready_cnt - r0 != 1) begin n_fail++; $display("FAIL single_count: pulses=%0d, required 1", ready_cnt - r0); end
    if (last_ready_cyc != start_cyc + 620) begin
      n_fail++; $display("FAIL single_latency: pulse at +%0d clk, required +620", last_ready_cyc - start_cyc);
    end
    if (ferr_cnt != f0) begin n_fail++; $display("FAIL single_ferr: ferr pulses=%0d, required 0", ferr_cnt - f0); end
    if (rxData !== 8'hA5) begin n_fail++; $display("FAIL single_hold: rxData=%02h, required a5", rxData); end
    $display("single byte a5 checked");
  endtask

  task automatic test_back_to_back;
    int r0, f0;
    r0 = ready_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'h00);
    send_frame(8'h00, 62, 1'b1, -1, -1);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 62, 1'b1, -1, -1);
    idle(60);
    n_checks += 2;
    if (ready_cnt - r0 != 2) begin n_fail++; $display("FAIL b2b_count: pulses=%0d, required 2", ready_cnt - r0); end
    if (ferr_cnt != f0) begin n_fail++; $display("FAIL b2b_ferr: ferr pulses=%0d, required 0", ferr_cnt - f0); end
    $display("back-to-back 00/ff checked");
  endtask

  task automatic test_glitch;
    int r0, f0;
    logic busy_mid;
    r0 = ready_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    idle(6);
    busy_mid = rxBusy;
    idle(14);
    rx = 1'b1;
    idle(100);
    n_checks += 4;
    if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hi: rxBusy=%0b, required 1", busy_mid); end
    if (rxBusy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_lo: rxBusy=%0b, required 0", rxBusy); end
    if (ready_cnt != r0) begin n_fail++; $display("FAIL glitch_ready: pulses=%0d, required 0", ready_cnt - r0); end
    if (ferr_cnt != f0) begin n_fail++; $display("FAIL glitch_ferr: pulses=%0d, required 0", ferr_cnt - f0); end
    $display("start glitch checked");
  endtask

  task automatic test_spike;
    int r0;
    r0 = ready_cnt;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 64, 1'b1, 4, -1);
    idle(40);
    n_checks += 1;
    if (ready_cnt - r0 != 1) begin n_fail++; $display("FAIL spike_count: pulses=%0d, required 1", ready_cnt - r0); end
    $display("bit-3 spike checked");
  endtask

  task automatic test_frame_err;
    int r0, f0;
    r0 = ready_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 64, 1'b0, -1, -1);
    idle(100);
    n_checks += 3;
    if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_count: pulses=%0d, required 1", ferr_cnt - f0); end
    if (ready_cnt != r0) begin n_fail++; $display("FAIL ferr_ready: pulses=%0d, required 0", ready_cnt - r0); end
    if (rxData !== 8'hFF) begin n_fail++; $display("FAIL ferr_hold: rxData=%02h, required ff", rxData); end
    exp_q.push_back(8'h11);
    send_frame(8'h11, 64, 1'b1, -1, -1);
    idle(40);
    n_checks += 1;
    if (ready_cnt - r0 != 1) begin n_fail++; $display("FAIL ferr_next: pulses=%0d, required 1", ready_cnt - r0); end
    $display("frame error then 11 checked");
  endtask

  task automatic test_mid_reset;
    int r0;
    r0 = ready_cnt;
    send_frame(8'h55, 64, 1'b1, -1, 5);
    idle(100);
    n_checks += 2;
    if (ready_cnt != r0) begin n_fail++; $display("FAIL rst_abandon: pulses=%0d, required 0", ready_cnt - r0); end
    if (rxBusy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: rxBusy=%0b, required 0", rxBusy); end
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 64, 1'b1, -1, -1);
    idle(40);
    n_checks += 2;
    if (ready_cnt - r0 != 1) begin n_fail++; $display("FAIL rst_next: pulses=%0d, required 1", ready_cnt - r0); end
    if (rxData !== 8'h0F) begin n_fail++; $display("FAIL rst_next_data: rxData=%02h, required 0f", rxData); end
    $display("mid-frame reset checked");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_spike();
    test_frame_err();
    test_mid_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d bytes outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 SHALL provide parameter CLKS_PER_TICK, default 27, clk cycles per 1/16-bit sample tick (50 MHz / (16*27) ~ 115200 baud).
REQ-002 SHALL provide parameter MIN_TICKS, default 2; a CLKS_PER_TICK below this is a configuration error.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rxReady  output  1  one-cycle pulse: new byte valid on rxData.
REQ-007 SHALL have port rxData  output  8  last correctly framed byte; held until the next good byte.
REQ-008 SHALL have port rxFrameErr  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port rxBusy  output  1  high from start-bit detection until return to IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-011 SHALL generate a tick strobe from a divider counting 0..CLKS_PER_TICK-1; the divider is cleared on start-edge detection so bit timing aligns to the edge.
REQ-012 SHALL use states IDLE, START, DATA, STOP, BREAK, with a 4-bit tick counter (0..15) per bit and a 3-bit bit index.
REQ-013 IDLE: on rxs falling edge (previous 1, current 0) SHALL clear the divider and tick counter and enter START.
REQ-014 In every bit period SHALL sample rxs at ticks 7, 8 and 9 and take the 2-of-3 majority as the bit value at tick 9.
REQ-015 START: majority 1 (false start/glitch) SHALL return to IDLE with no output pulse; majority 0 SHALL proceed, entering DATA at tick 15.
REQ-016 DATA: SHALL shift majority values into a shift register LSB first; after bit index 7 completes at tick 15, SHALL enter STOP.
REQ-017 STOP: at tick 9, majority 1 SHALL load rxData from the shift register and pulse rxReady on the next clk, then enter IDLE without waiting for ticks 10-15.
REQ-018 STOP: at tick 9, majority 0 SHALL pulse rxFrameErr on the next clk, leave rxData unchanged, and enter BREAK.
REQ-019 BREAK: SHALL stay until rxs is 1 for one full tick period, then enter IDLE; no falling edge is recognised in BREAK.
REQ-020 Latency: rxReady SHALL assert exactly 2 clk after the tick-9 strobe of the stop bit (1 for majority register, 1 for output register); rxReady and rxFrameErr SHALL never assert together.
REQ-021 A start edge arriving immediately after REQ-017's return to IDLE SHALL be accepted (back-to-back bytes at up to +3% sender rate).
REQ-022 rxBusy SHALL be high in START, DATA, STOP, BREAK and low in IDLE.
REQ-023 rxReady SHALL be a single-cycle pulse regardless of consumer; no handshake or buffering beyond rxData is provided; an unconsumed byte is overwritten by the next.

Reset
REQ-024 While reset is high SHALL force state IDLE, divider, tick and bit counters 0, synchronizer flops 1, rxData 8'h00, rxReady 0, rxFrameErr 0, rxBusy 0.
REQ-025 Reset asserted mid-frame SHALL abandon the byte with no pulse; after release, reception resumes only on a fresh falling edge.

Verification (CLKS_PER_TICK=4, 64 clk per bit)
REQ-026 Send 8'hA5 framed correctly -> rxData=8'hA5, one rxReady pulse 2 clk after stop-bit tick 9, rxFrameErr never high.
REQ-027 Send 8'h00 then 8'hFF back-to-back, no idle gap, sender 3% fast -> two rxReady pulses, rxData 8'h00 then 8'hFF.
REQ-028 Low glitch of 20 clk on idle line -> return to IDLE, no rxReady, no rxFrameErr, rxBusy high then low.
REQ-029 Send 8'h3C with stop bit low, then line high -> one rxFrameErr pulse, rxData keeps previous value, next byte 8'h11 received correctly.
REQ-030 Single-tick low spike on bit 3 of 8'hFF centred on tick 8 -> majority rejects it, rxData=8'hFF.
REQ-031 Assert reset for 1 clk during bit 4 of 8'h55, release -> no pulse for that frame; next frame 8'h0F gives rxData=8'h0F.
